// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit.
// Contents:
//   OP_*      5-bit opcode constants (IR[31:27]).
//   ALU_ADD   ALU code used for address and branch-offset arithmetic.
//   state_t   control-step enumeration (T0..T7, HALT).
//   iclass_t  instruction classes produced by control_decode.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LD, C_LDI, C_ST, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_JAL, C_IO, C_MF, C_NOP, C_HALT, C_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/control_decode.sv
// Opcode-to-class decoder.
// Ports:
//   opcode  in  5   IR[31:27]
//   iclass  out     instruction class; anything unassigned is C_ILLEGAL
module control_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass
);

  always_comb begin
    iclass = C_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:       iclass = C_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:              iclass = C_ALU_I;
      OP_LD:                                 iclass = C_LD;
      OP_LDI:                                iclass = C_LDI;
      OP_ST:                                 iclass = C_ST;
      OP_MUL, OP_DIV:                        iclass = C_MULDIV;
      OP_NEG, OP_NOT:                        iclass = C_UNARY;
      OP_BR:                                 iclass = C_BR;
      OP_JR:                                 iclass = C_JR;
      OP_JAL:                                iclass = C_JAL;
      OP_IN, OP_OUT:                         iclass = C_IO;
      OP_MFHI, OP_MFLO:                      iclass = C_MF;
      OP_NOP:                                iclass = C_NOP;
      OP_HALT:                               iclass = C_HALT;
      default:                               iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch (T0..T2) followed by a per-class
// execute sequence (T3..T7), plus a HALT state left only through clear.
// Ports:
//   clock, clear            rising-edge clock, synchronous active-high reset
//   IR[31:0], CON, stop     instruction, branch condition, halt request
//   *out                    bus source selects (at most one per cycle)
//   *_enable, IncPC         register load strobes
//   Read, Write             memory strobes (never together)
//   GRA..CON_in             register-select controls
//   register_enable_signals direct load, only bit 15 (R15) for jal
//   operation[4:0]          ALU opcode
//   run                     high unless halted or in reset
//   fsm_state               current control step, for observation
// Handshake: none; every strobe is a single-cycle level decoded from the
// current step and IR[31:27], and is forced low while clear is high.
module control_unit
  import cpu_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout,
  output logic        MAR_enable, PC_enable, IncPC, MDR_enable, IR_enable, Y_enable,
  output logic        Z_low_enable, Z_high_enable, HI_enable, LO_enable, OutPort_enable,
  output logic        Read, Write,
  output logic        GRA, GRB, GRC, Rin, Rout, BAout, CON_in,
  output logic [15:0] register_enable_signals,
  output logic [4:0]  operation,
  output logic        run,
  output state_t      fsm_state
);

  state_t     state, state_next;
  iclass_t    iclass;
  logic [4:0] opcode;
  logic       last;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign fsm_state = state;

  control_decode u_decode (
    .opcode (opcode),
    .iclass (iclass)
  );

  always_ff @(posedge clock) begin
    if (clear) state <= T0;
    else       state <= state_next;
  end

  // 'last' marks the final step of an instruction; the return to T0 is
  // where stop is honoured.
  always_comb begin
    state_next = state;
    last       = 1'b0;
    case (state)
      T0: state_next = T1;
      T1: state_next = T2;
      T2: begin
        case (iclass)
          C_HALT:    state_next = HALT;
          C_NOP:     last = 1'b1;
          C_ILLEGAL: if (HALT_ON_ILLEGAL) state_next = HALT; else last = 1'b1;
          default:   state_next = T3;
        endcase
      end
      T3: if (iclass inside {C_JR, C_IO, C_MF})            last = 1'b1; else state_next = T4;
      T4: if (iclass inside {C_UNARY, C_JAL})              last = 1'b1; else state_next = T5;
      T5: if (iclass inside {C_ALU_R, C_ALU_I, C_LDI})     last = 1'b1; else state_next = T6;
      T6: if (iclass inside {C_MULDIV, C_BR})              last = 1'b1; else state_next = T7;
      T7: last = 1'b1;
      HALT: state_next = HALT;
      default: state_next = T0;
    endcase
    if (last) state_next = stop ? HALT : T0;
  end

  always_comb begin
    {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout} = '0;
    {MAR_enable, PC_enable, IncPC, MDR_enable, IR_enable, Y_enable,
     Z_low_enable, Z_high_enable, HI_enable, LO_enable, OutPort_enable} = '0;
    {Read, Write} = '0;
    {GRA, GRB, GRC, Rin, Rout, BAout, CON_in} = '0;
    register_enable_signals = '0;
    operation = '0;
    run       = 1'b0;
    if (!clear) begin
      run = (state != HALT);
      case (state)
        T0: begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; end
        T1: begin Read = 1'b1; MDR_enable = 1'b1; end
        T2: begin MDRout = 1'b1; IR_enable = 1'b1; end
        T3: case (iclass)
          C_ALU_R, C_ALU_I: begin GRB = 1'b1; Rout = 1'b1; Y_enable = 1'b1; operation = opcode; end
          C_LD, C_LDI, C_ST: begin GRB = 1'b1; BAout = 1'b1; Y_enable = 1'b1; operation = ALU_ADD; end
          C_MULDIV: begin GRA = 1'b1; Rout = 1'b1; Y_enable = 1'b1; operation = opcode; end
          C_UNARY:  begin GRB = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; operation = opcode; end
          C_BR:     begin GRA = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
          C_JR:     begin GRA = 1'b1; Rout = 1'b1; PC_enable = 1'b1; end
          C_JAL:    begin PCout = 1'b1; register_enable_signals = 16'h8000; end
          C_IO: begin
            GRA = 1'b1;
            if (opcode == OP_IN) begin InPortout = 1'b1; Rin = 1'b1; end
            else begin Rout = 1'b1; OutPort_enable = 1'b1; end
          end
          C_MF: begin
            GRA = 1'b1; Rin = 1'b1;
            if (opcode == OP_MFHI) HIout = 1'b1; else LOout = 1'b1;
          end
          default: ;
        endcase
        T4: case (iclass)
          C_ALU_R:  begin GRC = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; operation = opcode; end
          C_ALU_I:  begin Cout = 1'b1; Z_low_enable = 1'b1; operation = opcode; end
          C_LD, C_LDI, C_ST: begin Cout = 1'b1; Z_low_enable = 1'b1; operation = ALU_ADD; end
          C_MULDIV: begin
            GRB = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; Z_high_enable = 1'b1; operation = opcode;
          end
          C_UNARY:  begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_BR:     begin PCout = 1'b1; Y_enable = 1'b1; operation = ALU_ADD; end
          C_JAL:    begin GRA = 1'b1; Rout = 1'b1; PC_enable = 1'b1; end
          default: ;
        endcase
        T5: case (iclass)
          C_ALU_R, C_ALU_I, C_LDI: begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_LD, C_ST: begin ZLowout = 1'b1; MAR_enable = 1'b1; end
          C_MULDIV:   begin ZLowout = 1'b1; LO_enable = 1'b1; end
          C_BR:       begin Cout = 1'b1; Z_low_enable = 1'b1; operation = ALU_ADD; end
          default: ;
        endcase
        T6: case (iclass)
          C_LD:     begin Read = 1'b1; MDR_enable = 1'b1; end
          // MDR loads from the bus here, so Read must stay low.
          C_ST:     begin GRA = 1'b1; Rout = 1'b1; MDR_enable = 1'b1; end
          C_MULDIV: begin ZHighout = 1'b1; HI_enable = 1'b1; end
          C_BR:     if (CON) begin ZLowout = 1'b1; PC_enable = 1'b1; end
          default: ;
        endcase
        T7: case (iclass)
          C_LD:    begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: two instances (HALT_ON_ILLEGAL = 0 and 1) share
// all inputs. Expected per-cycle control words come from a table of
// instruction step sequences built in build_seq.
module tb_control_unit;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR    = '0;
  logic        CON   = 1'b0;
  logic        stop  = 1'b0;

  always #5 clock = ~clock;

  wire [7:0]  src0, src1;
  wire [10:0] ld0, ld1;
  wire [1:0]  mem0, mem1;
  wire [6:0]  rs0, rs1;
  wire [15:0] ren0, ren1;
  wire [4:0]  op0, op1;
  wire        run0, run1;
  state_t     st0, st1;

  control_unit #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .stop(stop),
    .PCout(src0[0]), .ZLowout(src0[1]), .ZHighout(src0[2]), .MDRout(src0[3]),
    .HIout(src0[4]), .LOout(src0[5]), .InPortout(src0[6]), .Cout(src0[7]),
    .MAR_enable(ld0[0]), .PC_enable(ld0[1]), .IncPC(ld0[2]), .MDR_enable(ld0[3]),
    .IR_enable(ld0[4]), .Y_enable(ld0[5]), .Z_low_enable(ld0[6]), .Z_high_enable(ld0[7]),
    .HI_enable(ld0[8]), .LO_enable(ld0[9]), .OutPort_enable(ld0[10]),
    .Read(mem0[0]), .Write(mem0[1]),
    .GRA(rs0[0]), .GRB(rs0[1]), .GRC(rs0[2]), .Rin(rs0[3]), .Rout(rs0[4]),
    .BAout(rs0[5]), .CON_in(rs0[6]),
    .register_enable_signals(ren0), .operation(op0), .run(run0), .fsm_state(st0)
  );

  control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .stop(stop),
    .PCout(src1[0]), .ZLowout(src1[1]), .ZHighout(src1[2]), .MDRout(src1[3]),
    .HIout(src1[4]), .LOout(src1[5]), .InPortout(src1[6]), .Cout(src1[7]),
    .MAR_enable(ld1[0]), .PC_enable(ld1[1]), .IncPC(ld1[2]), .MDR_enable(ld1[3]),
    .IR_enable(ld1[4]), .Y_enable(ld1[5]), .Z_low_enable(ld1[6]), .Z_high_enable(ld1[7]),
    .HI_enable(ld1[8]), .LO_enable(ld1[9]), .OutPort_enable(ld1[10]),
    .Read(mem1[0]), .Write(mem1[1]),
    .GRA(rs1[0]), .GRB(rs1[1]), .GRC(rs1[2]), .Rin(rs1[3]), .Rout(rs1[4]),
    .BAout(rs1[5]), .CON_in(rs1[6]),
    .register_enable_signals(ren1), .operation(op1), .run(run1), .fsm_state(st1)
  );

  // Observed control word: bit 30 flags any register_enable bit other than R15.
  logic [30:0] obs0, obs1;
  assign obs0 = {|(ren0 & 16'h7fff), run0, ren0 == 16'h8000, rs0, mem0, ld0, src0};
  assign obs1 = {|(ren1 & 16'h7fff), run1, ren1 == 16'h8000, rs1, mem1, ld1, src1};

  localparam logic [30:0] M_PCO  = 31'd1 << 0,  M_ZLO  = 31'd1 << 1,  M_ZHO  = 31'd1 << 2;
  localparam logic [30:0] M_MDRO = 31'd1 << 3,  M_HIO  = 31'd1 << 4,  M_LOO  = 31'd1 << 5;
  localparam logic [30:0] M_INP  = 31'd1 << 6,  M_CO   = 31'd1 << 7,  M_MARE = 31'd1 << 8;
  localparam logic [30:0] M_PCE  = 31'd1 << 9,  M_INC  = 31'd1 << 10, M_MDRE = 31'd1 << 11;
  localparam logic [30:0] M_IRE  = 31'd1 << 12, M_YE   = 31'd1 << 13, M_ZLE  = 31'd1 << 14;
  localparam logic [30:0] M_ZHE  = 31'd1 << 15, M_HIE  = 31'd1 << 16, M_LOE  = 31'd1 << 17;
  localparam logic [30:0] M_OUTE = 31'd1 << 18, M_RD   = 31'd1 << 19, M_WR   = 31'd1 << 20;
  localparam logic [30:0] M_GRA  = 31'd1 << 21, M_GRB  = 31'd1 << 22, M_GRC  = 31'd1 << 23;
  localparam logic [30:0] M_RIN  = 31'd1 << 24, M_ROUT = 31'd1 << 25, M_BA   = 31'd1 << 26;
  localparam logic [30:0] M_CONI = 31'd1 << 27, M_R15  = 31'd1 << 28, M_RUN  = 31'd1 << 29;
  localparam logic [30:0] T0_WORD = M_RUN | M_PCO | M_MARE | M_INC;

  logic [30:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // Step list of one instruction, T0 first; to_halt says whether HALT follows.
  function automatic void build_seq(input logic [4:0] op, input logic con, input bit hoi,
                                    output bit to_halt);
    logic [30:0] s[$];
    to_halt = 1'b0;
    s = {M_PCO | M_MARE | M_INC, M_RD | M_MDRE, M_MDRO | M_IRE};
    if (op >= OP_ADD && op <= OP_SHL)
      s = {s, M_GRB | M_ROUT | M_YE, M_GRC | M_ROUT | M_ZLE, M_ZLO | M_GRA | M_RIN};
    else if (op >= OP_ADDI && op <= OP_ORI)
      s = {s, M_GRB | M_ROUT | M_YE, M_CO | M_ZLE, M_ZLO | M_GRA | M_RIN};
    else if (op == OP_LD)
      s = {s, M_GRB | M_BA | M_YE, M_CO | M_ZLE, M_ZLO | M_MARE, M_RD | M_MDRE,
           M_MDRO | M_GRA | M_RIN};
    else if (op == OP_LDI)
      s = {s, M_GRB | M_BA | M_YE, M_CO | M_ZLE, M_ZLO | M_GRA | M_RIN};
    else if (op == OP_ST)
      s = {s, M_GRB | M_BA | M_YE, M_CO | M_ZLE, M_ZLO | M_MARE,
           M_GRA | M_ROUT | M_MDRE, M_WR};
    else if (op == OP_MUL || op == OP_DIV)
      s = {s, M_GRA | M_ROUT | M_YE, M_GRB | M_ROUT | M_ZLE | M_ZHE, M_ZLO | M_LOE,
           M_ZHO | M_HIE};
    else if (op == OP_NEG || op == OP_NOT)
      s = {s, M_GRB | M_ROUT | M_ZLE, M_ZLO | M_GRA | M_RIN};
    else if (op == OP_BR)
      s = {s, M_GRA | M_ROUT | M_CONI, M_PCO | M_YE, M_CO | M_ZLE,
           con ? (M_ZLO | M_PCE) : 31'd0};
    else if (op == OP_JR)   s.push_back(M_GRA | M_ROUT | M_PCE);
    else if (op == OP_JAL)  s = {s, M_PCO | M_R15, M_GRA | M_ROUT | M_PCE};
    else if (op == OP_IN)   s.push_back(M_INP | M_GRA | M_RIN);
    else if (op == OP_OUT)  s.push_back(M_GRA | M_ROUT | M_OUTE);
    else if (op == OP_MFHI) s.push_back(M_HIO | M_GRA | M_RIN);
    else if (op == OP_MFLO) s.push_back(M_LOO | M_GRA | M_RIN);
    else if (op == OP_HALT) to_halt = 1'b1;
    else if (op != OP_NOP)  to_halt = hoi;
    exp_q.delete();
    foreach (s[i]) exp_q.push_back(s[i] | M_RUN);
  endfunction

  function automatic logic [4:0] exp_alu_op(input logic [4:0] op);
    return (op <= OP_ST || op == OP_BR) ? ALU_ADD : op;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves both instances at the start of a T0 cycle.
  task automatic restart();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    stop  = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      vectors += 2;
      if (obs0 !== 31'd0) begin miscompares++; $display("FAIL reset_outputs0 got %h required 0", obs0); end
      if (obs1 !== 31'd0) begin miscompares++; $display("FAIL reset_outputs1 got %h required 0", obs1); end
      tick();
    end
    clear = 1'b0;
    @(negedge clock);
    vectors += 2;
    if (obs0 !== T0_WORD) begin miscompares++; $display("FAIL reset_release got %h required %h", obs0, T0_WORD); end
    if (st0 !== T0) begin miscompares++; $display("FAIL reset_state got %0d required %0d", st0, T0); end
    tick();
  endtask

  task automatic test_add();
    bit h;
    logic [30:0] e;
    IR = {OP_ADD, 4'd1, 4'd2, 4'd3, 15'($urandom)};
    restart();
    build_seq(OP_ADD, 1'b0, 1'b0, h);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      vectors++;
      if (obs0 !== e) begin miscompares++; $display("FAIL add_step%0d got %h required %h", i, obs0, e); end
      if (i >= 3 && i <= 4) begin
        vectors++;
        if (op0 !== 5'b00011) begin miscompares++; $display("FAIL add_operation%0d got %b required 00011", i, op0); end
      end
      tick();
    end
    @(negedge clock);
    vectors++;
    if (obs0 !== T0_WORD) begin miscompares++; $display("FAIL add_return_t0 got %h required %h", obs0, T0_WORD); end
  endtask

  task automatic test_ld();
    bit h;
    logic [30:0] e;
    logic [7:0] rd_cycles = '0, mdro_cycles = '0;
    int n;
    IR = {OP_LD, 27'($urandom)};
    restart();
    build_seq(OP_LD, 1'b0, 1'b0, h);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      vectors++;
      if (obs0 !== e) begin miscompares++; $display("FAIL ld_step%0d got %h required %h", i, obs0, e); end
      rd_cycles[i]   = src0[3] ? 1'b0 : mem0[0];
      mdro_cycles[i] = src0[3];
      tick();
    end
    @(negedge clock);
    vectors += 3;
    if (rd_cycles !== 8'b0100_0010) begin miscompares++; $display("FAIL ld_read_cycles got %b required 01000010", rd_cycles); end
    if (mdro_cycles !== 8'b1000_0100) begin miscompares++; $display("FAIL ld_mdrout_cycles got %b required 10000100", mdro_cycles); end
    if (obs0 !== T0_WORD) begin miscompares++; $display("FAIL ld_length got %h at cycle 8 required %h", obs0, T0_WORD); end
  endtask

  task automatic test_br();
    bit h;
    logic [30:0] e;
    logic [6:0] pce;
    for (int c = 0; c < 2; c++) begin
      CON = c[0];
      IR  = {OP_BR, 27'($urandom)};
      restart();
      build_seq(OP_BR, CON, 1'b0, h);
      pce = '0;
      for (int i = 0; i < 7; i++) begin
        @(negedge clock);
        e = exp_q.pop_front();
        vectors++;
        if (obs0 !== e) begin miscompares++; $display("FAIL br_con%0d_step%0d got %h required %h", c, i, obs0, e); end
        if (e & M_ZLE) begin
          vectors++;
          if (op0 !== ALU_ADD) begin miscompares++; $display("FAIL br_operation got %b required %b", op0, ALU_ADD); end
        end
        pce[i] = ld0[1];
        tick();
      end
      vectors++;
      if (pce !== (c == 1 ? 7'b100_0000 : 7'b000_0000)) begin
        miscompares++; $display("FAIL br_con%0d_pc_enable got %b", c, pce);
      end
    end
    CON = 1'b0;
  endtask

  task automatic test_stop_halt();
    bit h;
    logic [30:0] e;
    IR = {OP_ADDI, 27'($urandom)};
    restart();
    build_seq(OP_ADDI, 1'b0, 1'b0, h);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) stop = 1'b1;
      @(negedge clock);
      e = exp_q.pop_front();
      vectors++;
      if (obs0 !== e) begin miscompares++; $display("FAIL stop_addi_step%0d got %h required %h", i, obs0, e); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors += 2;
      if (obs0 !== 31'd0) begin miscompares++; $display("FAIL stop_halt%0d got %h required 0", i, obs0); end
      if (st0 !== HALT) begin miscompares++; $display("FAIL stop_halt_state got %0d required %0d", st0, HALT); end
      tick();
    end
    stop = 1'b0;
    restart();
    @(negedge clock);
    vectors++;
    if (obs0 !== T0_WORD) begin miscompares++; $display("FAIL stop_clear_exit got %h required %h", obs0, T0_WORD); end
    tick();
  endtask

  task automatic test_clear_mid_st();
    bit h;
    logic [30:0] e;
    logic wr_seen = 1'b0;
    IR = {OP_ST, 27'($urandom)};
    restart();
    build_seq(OP_ST, 1'b0, 1'b0, h);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      vectors++;
      if (obs0 !== e) begin miscompares++; $display("FAIL st_step%0d got %h required %h", i, obs0, e); end
      wr_seen |= mem0[1];
      tick();
    end
    clear = 1'b1;
    @(negedge clock);
    vectors++;
    if (obs0 !== 31'd0) begin miscompares++; $display("FAIL st_clear_outputs got %h required 0", obs0); end
    wr_seen |= mem0[1];
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      wr_seen |= mem0[1];
      if (i == 0) begin
        vectors++;
        if (obs0 !== T0_WORD) begin miscompares++; $display("FAIL st_clear_next got %h required %h", obs0, T0_WORD); end
      end
      tick();
    end
    vectors++;
    if (wr_seen !== 1'b0) begin miscompares++; $display("FAIL st_clear_write got %b required 0", wr_seen); end
  endtask

  task automatic test_illegal();
    logic [4:0] ops[3];
    bit h0, h1;
    logic [30:0] e;
    ops[0] = 5'b11111;
    ops[1] = 5'($urandom_range(28, 30));
    ops[2] = OP_HALT;
    foreach (ops[k]) begin
      IR = {ops[k], 27'($urandom)};
      restart();
      build_seq(ops[k], 1'b0, 1'b1, h1);
      build_seq(ops[k], 1'b0, 1'b0, h0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        e = exp_q.pop_front();
        vectors += 2;
        if (obs0 !== e) begin miscompares++; $display("FAIL illegal%0d_step%0d inst0 got %h required %h", k, i, obs0, e); end
        if (obs1 !== e) begin miscompares++; $display("FAIL illegal%0d_step%0d inst1 got %h required %h", k, i, obs1, e); end
        tick();
      end
      for (int i = 0; i < 2; i++) begin
        @(negedge clock);
        vectors += 2;
        if (i == 0 && obs0 !== (h0 ? 31'd0 : T0_WORD)) begin
          miscompares++; $display("FAIL illegal%0d_after_t2 inst0 got %h", k, obs0);
        end
        if (i == 1 && run0 !== !h0) begin miscompares++; $display("FAIL illegal%0d_run inst0 got %b", k, run0); end
        if (obs1 !== (h1 ? 31'd0 : (i == 0 ? T0_WORD : M_RUN | M_RD | M_MDRE))) begin
          miscompares++; $display("FAIL illegal%0d_after_t2 inst1 got %h", k, obs1);
        end
        tick();
      end
    end
  endtask

  // Back-to-back random legal instructions (everything except halt).
  task automatic test_back_to_back();
    bit h;
    logic [30:0] e;
    logic [4:0] op;
    int n;
    restart();
    for (int k = 0; k < 40; k++) begin
      op  = 5'($urandom_range(0, 26));
      CON = 1'($urandom);
      IR  = {op, 27'($urandom)};
      build_seq(op, CON, 1'b0, h);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        @(negedge clock);
        e = exp_q.pop_front();
        vectors += 2;
        if (obs0 !== e) begin miscompares++; $display("FAIL rand%0d_op%b_step%0d inst0 got %h required %h", k, op, i, obs0, e); end
        if (obs1 !== e) begin miscompares++; $display("FAIL rand%0d_op%b_step%0d inst1 got %h required %h", k, op, i, obs1, e); end
        if (e & M_ZLE) begin
          vectors++;
          if (op0 !== exp_alu_op(op)) begin
            miscompares++; $display("FAIL rand%0d_operation got %b required %b", k, op0, exp_alu_op(op));
          end
        end
        tick();
      end
    end
    CON = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_br();
    test_stop_halt();
    test_clear_mid_st();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
